// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared states, LED bit positions, lamp patterns and decode helpers
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_LAMP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } tlc_state_e;

  localparam int LED_HRED    = 7;
  localparam int LED_HYELLOW = 6;
  localparam int LED_HGREEN  = 5;
  localparam int LED_HLEFT   = 4;
  localparam int LED_FRED    = 3;
  localparam int LED_FYELLOW = 2;
  localparam int LED_FGREEN  = 1;
  localparam int LED_FLEFT   = 0;

  localparam logic [7:0] LED_ALL_ON   = 8'hFF;
  localparam logic [7:0] LED_FAULT_ON = 8'h88;

  // Farm green has no dedicated control line; it is lit whenever no other farm lamp is.
  function automatic logic [7:0] led_map(input logic hred, input logic hyellow,
                                         input logic hgreen, input logic hleft,
                                         input logic fred, input logic fyellow,
                                         input logic fleft);
    logic [7:0] m;
    m              = '0;
    m[LED_HRED]    = hred;
    m[LED_HYELLOW] = hyellow;
    m[LED_HGREEN]  = hgreen;
    m[LED_HLEFT]   = hleft;
    m[LED_FRED]    = fred;
    m[LED_FYELLOW] = fyellow;
    m[LED_FGREEN]  = ~fred & ~fyellow & ~fleft;
    m[LED_FLEFT]   = fleft;
    return m;
  endfunction

  function automatic logic conflict(input logic hred, input logic hyellow,
                                    input logic hgreen, input logic hleft,
                                    input logic fred, input logic fyellow,
                                    input logic fleft);
    logic h_go;
    h_go = hgreen | hyellow | hleft;
    return (h_go & ~fred) | (hred & h_go) | (fred & (fyellow | fleft)) | ~(hred | h_go);
  endfunction

endpackage

// File: rtl/tlc_blink_gen.sv
// rtl/tlc_blink_gen.sv - divider toggling a flash phase every DIV enabled cycles
module tlc_blink_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic phase_next_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  // Next phase is exported so the caller can register it alongside its own outputs.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_next_o = phase_d;

endmodule

// File: rtl/tlc_led_driver.sv
// rtl/tlc_led_driver.sv - LED output stage with lamp test and latched conflict watchdog
module tlc_led_driver #(
  parameter int BLINK_DIV = 25000000,
  parameter int LT_CYCLES = 50000000,
  parameter int FAULT_CNT = 3
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       FLEFT,
  input  logic       FRED,
  input  logic       FYELLOW,
  input  logic       HGREEN,
  input  logic       HLEFT,
  input  logic       HRED,
  input  logic       HYELLOW,
  input  logic       LAMP_TEST,
  output logic [7:0] LED,
  output logic       FAULT
);
  import tlc_pkg::*;

  localparam int LT_W = (LT_CYCLES > 1) ? $clog2(LT_CYCLES) : 1;
  localparam int FC_W = $clog2(FAULT_CNT + 1);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LT_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_TRIP = FC_W'(FAULT_CNT);

  tlc_state_e      state_q, state_d;
  logic [LT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [FC_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [7:0]      led_q, led_d;
  logic            fault_q, fault_d;
  logic            blink_clr, blink_en, blink_phase;
  logic            conflict_w;
  logic [7:0]      map_w;

  assign conflict_w = conflict(HRED, HYELLOW, HGREEN, HLEFT, FRED, FYELLOW, FLEFT);
  assign map_w      = led_map(HRED, HYELLOW, HGREEN, HLEFT, FRED, FYELLOW, FLEFT);

  tlc_blink_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk_i        (MCLK),
    .rst_i        (RESET),
    .clr_i        (blink_clr),
    .en_i         (blink_en),
    .phase_next_o (blink_phase)
  );

  always_comb begin
    state_d   = state_q;
    lt_cnt_d  = lt_cnt_q;
    flt_cnt_d = flt_cnt_q;
    led_d     = led_q;
    fault_d   = fault_q;
    blink_clr = 1'b0;
    blink_en  = 1'b0;
    unique case (state_q)
      ST_LAMP: begin
        led_d   = LED_ALL_ON;
        fault_d = 1'b0;
        if (lt_cnt_q == LT_LAST) begin
          state_d  = ST_RUN;
          lt_cnt_d = '0;
        end else begin
          lt_cnt_d = lt_cnt_q + LT_W'(1);
        end
      end
      ST_RUN: begin
        // Trip is acted on the edge after the count completes, whatever the inputs then are.
        if (flt_cnt_q == FC_TRIP) begin
          state_d   = ST_FAULT;
          fault_d   = 1'b1;
          blink_clr = 1'b1;
          led_d     = LED_FAULT_ON;
        end else begin
          led_d     = LAMP_TEST ? LED_ALL_ON : map_w;
          flt_cnt_d = conflict_w ? flt_cnt_q + FC_W'(1) : '0;
        end
      end
      ST_FAULT: begin
        fault_d  = 1'b1;
        blink_en = 1'b1;
        led_d    = blink_phase ? LED_FAULT_ON : 8'h00;
      end
      default: state_d = ST_LAMP;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q   <= ST_LAMP;
      lt_cnt_q  <= '0;
      flt_cnt_q <= '0;
      led_q     <= LED_ALL_ON;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lt_cnt_q  <= lt_cnt_d;
      flt_cnt_q <= flt_cnt_d;
      led_q     <= led_d;
      fault_q   <= fault_d;
    end
  end

  assign LED   = led_q;
  assign FAULT = fault_q;

endmodule

// File: tb/tb_tlc_led_driver.sv
// tb/tb_tlc_led_driver.sv - directed self-checking bench for tlc_led_driver
module tb_tlc_led_driver;

  localparam int BLINK_DIV = 4;
  localparam int LT_CYCLES = 8;
  localparam int FAULT_CNT = 3;

  // Input vectors ordered {HRED,HYELLOW,HGREEN,HLEFT,FRED,FYELLOW,FLEFT}
  localparam logic [6:0] IN_CLEAN    = 7'b1000_100;
  localparam logic [6:0] IN_HG_FR    = 7'b0010_100;
  localparam logic [6:0] IN_HR_ONLY  = 7'b1000_000;
  localparam logic [6:0] IN_HY_FR    = 7'b0100_100;
  localparam logic [6:0] IN_CONFLICT = 7'b0010_000;
  localparam logic [6:0] IN_NONE     = 7'b0000_000;

  logic       MCLK = 1'b0;
  logic       RESET = 1'b1;
  logic       FLEFT = 1'b0, FRED = 1'b0, FYELLOW = 1'b0;
  logic       HGREEN = 1'b0, HLEFT = 1'b0, HRED = 1'b0, HYELLOW = 1'b0;
  logic       LAMP_TEST = 1'b0;
  logic [7:0] LED;
  logic       FAULT;

  int pass_cnt = 0;
  int total_cnt = 0;

  tlc_led_driver #(
    .BLINK_DIV (BLINK_DIV),
    .LT_CYCLES (LT_CYCLES),
    .FAULT_CNT (FAULT_CNT)
  ) dut (
    .MCLK      (MCLK),
    .RESET     (RESET),
    .FLEFT     (FLEFT),
    .FRED      (FRED),
    .FYELLOW   (FYELLOW),
    .HGREEN    (HGREEN),
    .HLEFT     (HLEFT),
    .HRED      (HRED),
    .HYELLOW   (HYELLOW),
    .LAMP_TEST (LAMP_TEST),
    .LED       (LED),
    .FAULT     (FAULT)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_in(input logic [6:0] v);
    {HRED, HYELLOW, HGREEN, HLEFT, FRED, FYELLOW, FLEFT} = v;
  endtask

  // lamp_in is held during the lamp test to show conflicts are not watched there
  task automatic test_reset(input logic [6:0] lamp_in);
    RESET = 1'b1;
    set_in(lamp_in);
    tick();
    total_cnt++;
    if (LED !== 8'hFF) $display("FAIL reset_led got %h expected ff", LED); else pass_cnt++;
    total_cnt++;
    if (FAULT !== 1'b0) $display("FAIL reset_fault got %b expected 0", FAULT); else pass_cnt++;
    RESET = 1'b0;
    for (int i = 1; i <= LT_CYCLES; i++) begin
      tick();
      total_cnt++;
      if (LED !== 8'hFF || FAULT !== 1'b0)
        $display("FAIL lamp_cycle_%0d got led=%h fault=%b expected led=ff fault=0", i, LED, FAULT);
      else pass_cnt++;
    end
    set_in(IN_CLEAN);
    tick();
    total_cnt++;
    if (LED !== 8'h88 || FAULT !== 1'b0)
      $display("FAIL lamp_exit got led=%h fault=%b expected led=88 fault=0", LED, FAULT);
    else pass_cnt++;
  endtask

  task automatic test_map();
    set_in(IN_HG_FR);
    tick();
    total_cnt++;
    if (LED !== 8'b0010_1000 || FAULT !== 1'b0)
      $display("FAIL map_hg_fr got led=%h fault=%b expected led=28 fault=0", LED, FAULT);
    else pass_cnt++;
    set_in(IN_HR_ONLY);
    tick();
    total_cnt++;
    if (LED !== 8'b1000_0010)
      $display("FAIL map_fgreen got led=%h expected 82", LED);
    else pass_cnt++;
    set_in(IN_HY_FR);
    tick();
    total_cnt++;
    if (LED !== 8'b0100_1000)
      $display("FAIL map_hy_fr got led=%h expected 48", LED);
    else pass_cnt++;
  endtask

  task automatic test_lamp_test();
    set_in(IN_HG_FR);
    LAMP_TEST = 1'b1;
    tick();
    total_cnt++;
    if (LED !== 8'hFF) $display("FAIL lamp_test_on got %h expected ff", LED); else pass_cnt++;
    LAMP_TEST = 1'b0;
    tick();
    total_cnt++;
    if (LED !== 8'h28) $display("FAIL lamp_test_off got %h expected 28", LED); else pass_cnt++;
  endtask

  task automatic test_no_fault();
    set_in(IN_CONFLICT);
    tick();
    total_cnt++;
    if (LED !== 8'h22) $display("FAIL conflict_map got %h expected 22", LED); else pass_cnt++;
    tick();
    set_in(IN_CLEAN);
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (FAULT !== 1'b0 || LED !== 8'h88)
        $display("FAIL short_conflict_%0d got led=%h fault=%b expected led=88 fault=0", i, LED, FAULT);
      else pass_cnt++;
    end
  endtask

  // Flash pattern is checked while LAMP_TEST and inputs toggle, which must have no effect
  task automatic test_fault();
    logic [7:0] exp_led [9];
    exp_led = '{8'h88, 8'h88, 8'h88, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h88};
    set_in(IN_CONFLICT);
    tick();
    tick();
    tick();
    total_cnt++;
    if (FAULT !== 1'b0) $display("FAIL fault_early got %b expected 0", FAULT); else pass_cnt++;
    set_in(IN_CLEAN);
    for (int i = 0; i < 9; i++) begin
      tick();
      total_cnt++;
      if (FAULT !== 1'b1 || LED !== exp_led[i])
        $display("FAIL fault_blink_%0d got led=%h fault=%b expected led=%h fault=1", i, LED, FAULT, exp_led[i]);
      else pass_cnt++;
      LAMP_TEST = i[0];
      set_in(i[1] ? IN_HG_FR : IN_NONE);
    end
    LAMP_TEST = 1'b0;
  endtask

  task automatic test_lamp_test_conflict();
    set_in(IN_CONFLICT);
    LAMP_TEST = 1'b1;
    for (int i = 0; i < FAULT_CNT; i++) begin
      tick();
      total_cnt++;
      if (LED !== 8'hFF || FAULT !== 1'b0)
        $display("FAIL lt_conflict_%0d got led=%h fault=%b expected led=ff fault=0", i, LED, FAULT);
      else pass_cnt++;
    end
    set_in(IN_CLEAN);
    tick();
    total_cnt++;
    if (FAULT !== 1'b1 || LED !== 8'h88)
      $display("FAIL lt_conflict_trip got led=%h fault=%b expected led=88 fault=1", LED, FAULT);
    else pass_cnt++;
    LAMP_TEST = 1'b0;
  endtask

  initial begin
    test_reset(IN_CLEAN);
    test_map();
    test_lamp_test();
    test_no_fault();
    test_fault();
    test_reset(IN_NONE);
    test_lamp_test_conflict();
    test_reset(IN_CONFLICT);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
